// File: rtl/unison_oscillator.sv
// Unison oscillator: VOICES detuned phase accumulators summed and averaged
// into one 16-bit offset-binary sample per sample_tick, one voice per cycle.
//
// state | meaning
// IDLE  | waiting for sample_tick; inputs latched on accept
// RUN   | processing voice v, one voice per clock
// DONE  | publishing the averaged sample, strobing wave_valid
module unison_oscillator #(
  parameter int VOICES    = 4,
  parameter int PHASE_W   = 32,
  parameter int STEP_K    = 89478,
  parameter int DET_SHIFT = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_tick,
  input  logic [19:0] freq,
  input  logic [1:0]  ctrl,
  input  logic [3:0]  detune,
  input  logic [7:0]  pw,
  input  logic        sync,
  output logic [15:0] wave_out,
  output logic        wave_valid,
  output logic        busy,
  output logic        overrun
);

  localparam int LOG2V = $clog2(VOICES);
  localparam int AW    = 16 + LOG2V;
  localparam int VW    = (LOG2V > 0) ? LOG2V : 1;
  localparam logic [VW-1:0] V_LAST = VW'(VOICES - 1);

  // Quarter-wave sine, entry i = round(32767*sin(pi/2*(i+0.5)/64)).
  localparam logic [14:0] SINE_ROM [64] = '{
    15'd402,   15'd1206,  15'd2009,  15'd2811,  15'd3612,  15'd4410,  15'd5205,  15'd5998,
    15'd6786,  15'd7571,  15'd8351,  15'd9126,  15'd9896,  15'd10659, 15'd11417, 15'd12167,
    15'd12910, 15'd13645, 15'd14372, 15'd15090, 15'd15800, 15'd16499, 15'd17189, 15'd17869,
    15'd18537, 15'd19195, 15'd19841, 15'd20475, 15'd21096, 15'd21705, 15'd22301, 15'd22884,
    15'd23452, 15'd24007, 15'd24547, 15'd25072, 15'd25582, 15'd26077, 15'd26556, 15'd27019,
    15'd27466, 15'd27896, 15'd28310, 15'd28706, 15'd29085, 15'd29447, 15'd29791, 15'd30117,
    15'd30424, 15'd30714, 15'd30985, 15'd31237, 15'd31470, 15'd31685, 15'd31880, 15'd32057,
    15'd32213, 15'd32351, 15'd32469, 15'd32567, 15'd32646, 15'd32705, 15'd32745, 15'd32765
  };

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [VW-1:0]      v_q, v_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [19:0]        freq_q, freq_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic [3:0]         detune_q, detune_d;
  logic [7:0]         pw_q, pw_d;
  logic [PHASE_W-1:0] phase_q [VOICES];
  logic [PHASE_W-1:0] phase_d [VOICES];
  logic [15:0]        wave_out_q, wave_out_d;
  logic               wave_valid_q, wave_valid_d;
  logic               overrun_q, overrun_d;

  logic [PHASE_W-1:0] cur_phase;
  logic signed [31:0] d_v;
  logic signed [31:0] off_v;
  logic [17:0]        m_v;
  logic [PHASE_W-1:0] step_v;
  logic [15:0]        p;
  logic [5:0]         rom_addr;
  logic [14:0]        rom_q;
  logic [15:0]        wave_val;

  // Select the phase of the voice currently being processed.
  always_comb begin
    cur_phase = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (v_q == VW'(i)) cur_phase = phase_q[i];
    end
  end

  // Per-voice step: odd-symmetric detune offset around the base multiplier.
  always_comb begin
    d_v    = $signed(32'(v_q)) * 2 - (VOICES - 1);
    off_v  = (d_v * $signed(32'(detune_q))) <<< DET_SHIFT;
    m_v    = 18'(STEP_K + off_v);
    step_v = PHASE_W'(38'(m_v) * 38'(freq_q));
  end

  // Waveform shaping from the pre-update phase.
  always_comb begin
    p        = cur_phase[PHASE_W-1 -: 16];
    rom_addr = p[14] ? ~p[13:8] : p[13:8];
    rom_q    = SINE_ROM[rom_addr];
    wave_val = p;
    case (ctrl_q)
      2'b00: wave_val = p;
      2'b01: wave_val = (p < {pw_q, 8'h00}) ? 16'hFFFF : 16'h0000;
      2'b10: wave_val = p[15] ? (16'h8000 - {1'b0, rom_q}) : (16'h8000 + {1'b0, rom_q});
      2'b11: wave_val = p[15] ? ~{p[14:0], 1'b0} : {p[14:0], 1'b0};
      default: wave_val = p;
    endcase
  end

  // Phase update: sync clears every voice and wins over the RUN advance.
  always_comb begin
    for (int i = 0; i < VOICES; i++) begin
      phase_d[i] = phase_q[i];
      if (sync) begin
        phase_d[i] = '0;
      end else if (state_q == S_RUN && v_q == VW'(i)) begin
        phase_d[i] = phase_q[i] + step_v;
      end
    end
  end

  // Sequencer next-state, accumulation and output publishing.
  always_comb begin
    state_d      = state_q;
    v_d          = v_q;
    acc_d        = acc_q;
    freq_d       = freq_q;
    ctrl_d       = ctrl_q;
    detune_d     = detune_q;
    pw_d         = pw_q;
    wave_out_d   = wave_out_q;
    wave_valid_d = 1'b0;
    overrun_d    = overrun_q;
    case (state_q)
      S_IDLE: begin
        if (sample_tick) begin
          freq_d   = freq;
          ctrl_d   = ctrl;
          detune_d = detune;
          pw_d     = pw;
          acc_d    = '0;
          v_d      = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (sample_tick) overrun_d = 1'b1;
        acc_d = acc_q + AW'(wave_val);
        if (v_q == V_LAST) begin
          v_d     = '0;
          state_d = S_DONE;
        end else begin
          v_d = v_q + 1'b1;
        end
      end
      S_DONE: begin
        if (sample_tick) overrun_d = 1'b1;
        wave_out_d   = acc_q[LOG2V +: 16];
        wave_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      v_q          <= '0;
      acc_q        <= '0;
      freq_q       <= '0;
      ctrl_q       <= '0;
      detune_q     <= '0;
      pw_q         <= '0;
      wave_out_q   <= 16'h8000;
      wave_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < VOICES; i++) phase_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      v_q          <= v_d;
      acc_q        <= acc_d;
      freq_q       <= freq_d;
      ctrl_q       <= ctrl_d;
      detune_q     <= detune_d;
      pw_q         <= pw_d;
      wave_out_q   <= wave_out_d;
      wave_valid_q <= wave_valid_d;
      overrun_q    <= overrun_d;
      for (int i = 0; i < VOICES; i++) phase_q[i] <= phase_d[i];
    end
  end

  assign wave_out   = wave_out_q;
  assign wave_valid = wave_valid_q;
  assign busy       = (state_q != S_IDLE);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_unison_oscillator.sv
// Directed bench: a 4-voice and a 1-voice oscillator share stimulus.
module tb_unison_oscillator;

  logic        clk = 1'b0;
  logic        reset, sample_tick, sync;
  logic [19:0] freq;
  logic [1:0]  ctrl;
  logic [3:0]  detune;
  logic [7:0]  pw;
  logic [15:0] wave4, wave1;
  logic        valid4, valid1, busy4, busy1, ovr4, ovr1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  unison_oscillator #(.VOICES(4)) u_dut4 (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .freq(freq), .ctrl(ctrl),
    .detune(detune), .pw(pw), .sync(sync), .wave_out(wave4), .wave_valid(valid4),
    .busy(busy4), .overrun(ovr4)
  );

  unison_oscillator #(.VOICES(1)) u_dut1 (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .freq(freq), .ctrl(ctrl),
    .detune(detune), .pw(pw), .sync(sync), .wave_out(wave1), .wave_valid(valid1),
    .busy(busy1), .overrun(ovr1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Saw output of the tick that sees n prior phase advances of size step.
  function automatic logic [15:0] saw_exp(input int n, input longint step);
    longint ph;
    ph = (longint'(n) * step) & 64'hFFFF_FFFF;
    return 16'(ph >> 16);
  endfunction

  task automatic pulse_sync();
    @(posedge clk); #1 sync = 1'b1;
    @(posedge clk); #1 sync = 1'b0;
  endtask

  // One tick, then watch 12 edges for strobes; latency counted in edges after the tick edge.
  task automatic run_tick(input bit scramble, output logic [15:0] w1, output logic [15:0] w4,
                          output int lat1, output int lat4, output int n1, output int n4);
    logic [19:0] f_save;
    logic [1:0]  c_save;
    w1 = '0; w4 = '0; lat1 = -1; lat4 = -1; n1 = 0; n4 = 0;
    f_save = freq; c_save = ctrl;
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    if (scramble) begin
      freq = 20'hFFFFF;
      ctrl = ~ctrl;
    end
    @(negedge clk);
    chk("busy_after_tick", 32'(busy4), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); @(negedge clk);
      if (valid1) begin n1++; if (lat1 < 0) begin lat1 = k; w1 = wave1; end end
      if (valid4) begin n4++; if (lat4 < 0) begin lat4 = k; w4 = wave4; end end
    end
    chk("busy_idle", 32'(busy4), 32'd0);
    if (scramble) begin
      freq = f_save;
      ctrl = c_save;
    end
  endtask

  initial begin
    logic [15:0] w1, w4;
    int lat1, lat4, n1, n4, strobes;

    reset = 1'b1; sample_tick = 1'b0; sync = 1'b0;
    freq = 20'd1; ctrl = 2'b00; detune = 4'd0; pw = 8'h80;
    #2 reset = 1'b0;
    #1;
    chk("rst_wave4", 32'(wave4), 32'h8000);
    chk("rst_valid4", 32'(valid4), 32'd0);
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_ovr4", 32'(ovr4), 32'd0);
    chk("rst_wave1", 32'(wave1), 32'h8000);
    @(negedge clk) reset = 1'b1;

    // Saw, freq=1: sample n shows phase n*89478 >> 16 -> 0,1,2,4.
    for (int n = 0; n < 4; n++) begin
      run_tick(1'b0, w1, w4, lat1, lat4, n1, n4);
      chk($sformatf("saw1_%0d", n), 32'(w1), 32'(saw_exp(n, 64'd89478)));
      chk($sformatf("saw4_%0d", n), 32'(w4), 32'(saw_exp(n, 64'd89478)));
      chk("lat1", 32'(lat1), 32'd2);
      chk("lat4", 32'(lat4), 32'd5);
      chk("strobes1", 32'(n1), 32'd1);
      chk("strobes4", 32'(n4), 32'd1);
    end
    chk("saw1_tick3_const", 32'(w1), 32'd4);

    // Unison identity at 440 Hz; tick 2 scrambles inputs after the latch.
    freq = 20'd440;
    pulse_sync();
    for (int n = 0; n < 4; n++) begin
      run_tick(n == 2, w1, w4, lat1, lat4, n1, n4);
      chk($sformatf("u440_v1_%0d", n), 32'(w1), 32'(saw_exp(n, 64'd89478 * 64'd440)));
      chk($sformatf("u440_v4_%0d", n), 32'(w4), 32'(saw_exp(n, 64'd89478 * 64'd440)));
    end

    // Detune spread: phases (89478+k*512)*1000 >>16 = 1341,1357,1373,1388 -> sum 5459 >>2 = 1364.
    detune = 4'd1; freq = 20'd1000;
    pulse_sync();
    run_tick(1'b0, w1, w4, lat1, lat4, n1, n4);
    chk("det_first4", 32'(w4), 32'd0);
    run_tick(1'b0, w1, w4, lat1, lat4, n1, n4);
    chk("det_spread4", 32'(w4), 32'd1364);
    chk("det_single1", 32'(w1), 32'd1365);
    detune = 4'd0;

    // Modes at phase 0, then at p=0x0555 (89478000>>16).
    ctrl = 2'b01; pw = 8'h80;
    pulse_sync();
    run_tick(1'b0, w1, w4, lat1, lat4, n1, n4);
    chk("sq_half4", 32'(w4), 32'hFFFF);
    chk("sq_half1", 32'(w1), 32'hFFFF);
    pw = 8'h00;
    pulse_sync();
    run_tick(1'b0, w1, w4, lat1, lat4, n1, n4);
    chk("sq_pw0", 32'(w4), 32'h0000);
    ctrl = 2'b11;
    pulse_sync();
    run_tick(1'b0, w1, w4, lat1, lat4, n1, n4);
    chk("tri_zero", 32'(w4), 32'h0000);
    run_tick(1'b0, w1, w4, lat1, lat4, n1, n4);
    chk("tri_0555", 32'(w4), 32'h0AAA);
    ctrl = 2'b10;
    pulse_sync();
    run_tick(1'b0, w1, w4, lat1, lat4, n1, n4);
    chk("sine_zero4", 32'(w4), 32'h8192);
    chk("sine_zero1", 32'(w1), 32'h8192);
    run_tick(1'b0, w1, w4, lat1, lat4, n1, n4);
    chk("sine_rom5", 32'(w1), 32'h913A);

    // Overrun: second tick two edges after the first.
    chk("ovr_before", 32'(ovr4), 32'd0);
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    n1 = 0; n4 = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 1) sample_tick = 1'b1;
      if (k == 2) sample_tick = 1'b0;
      @(negedge clk);
      if (valid1) n1++;
      if (valid4) n4++;
    end
    chk("ovr_strobes4", 32'(n4), 32'd1);
    chk("ovr_strobes1", 32'(n1), 32'd1);
    chk("ovr_flag4", 32'(ovr4), 32'd1);
    chk("ovr_flag1", 32'(ovr1), 32'd1);
    run_tick(1'b0, w1, w4, lat1, lat4, n1, n4);
    chk("ovr_next_lat4", 32'(lat4), 32'd5);
    chk("ovr_sticky4", 32'(ovr4), 32'd1);

    // Reset mid-RUN: immediate defaults, no strobe afterwards.
    ctrl = 2'b01; pw = 8'h80;
    pulse_sync();
    run_tick(1'b0, w1, w4, lat1, lat4, n1, n4);
    chk("pre_rst_wave4", 32'(wave4), 32'hFFFF);
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    @(posedge clk); #2 reset = 1'b0;
    #1;
    chk("midrst_wave4", 32'(wave4), 32'h8000);
    chk("midrst_wave1", 32'(wave1), 32'h8000);
    chk("midrst_valid4", 32'(valid4), 32'd0);
    chk("midrst_busy4", 32'(busy4), 32'd0);
    chk("midrst_ovr4", 32'(ovr4), 32'd0);
    @(negedge clk); @(negedge clk) reset = 1'b1;
    strobes = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); @(negedge clk);
      if (valid4 || valid1) strobes++;
    end
    chk("midrst_no_strobe", 32'(strobes), 32'd0);
    chk("midrst_idle", 32'(busy4), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
